// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and the framebuffer colour type.
// Latency: none (declarations only).
// Backpressure: none.
package vga_pkg;

    // Horizontal timing in pixel ticks
    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    // Vertical timing in lines
    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    // Playfield held in the framebuffer; each pixel covers a 4x4 screen block
    localparam int FB_W = 160;
    localparam int FB_H = 120;

    // One bit per channel: bit 2 = R, bit 1 = G, bit 0 = B
    typedef logic [2:0] colour_t;

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick phase, h/v raster counters and the sync/blank/vblank/frame_start decode.
// Latency: decode outputs are combinational from the counters; frame_start is registered (1 clk).
// Backpressure: none; free-running raster.
module vga_timing
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    output logic       pix_en_o,
    output logic       phase_o,
    output logic [7:0] col_o,
    output logic [9:0] v_o,
    output logic       line_end_o,
    output logic       frame_end_o,
    output logic       hs_n_o,
    output logic       vs_n_o,
    output logic       vis_o,
    output logic       vblank_o,
    output logic       frame_start_o
);

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END = 10'(H_VIS);
    localparam logic [9:0] V_VIS_END = 10'(V_VIS);
    localparam logic [9:0] H_SYNC_LO = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_SYNC_HI = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_LO = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SYNC_HI = 10'(V_VIS + V_FP + V_SYNC);

    logic       phase_q, phase_d;
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       frame_start_q, frame_start_d;

    logic pix_en;
    logic line_end;
    logic frame_end;

    // 25 MHz tick: every second clk, on the phase==1 cycle
    assign pix_en    = phase_q;
    assign line_end  = pix_en && (h_q == H_LAST);
    assign frame_end = line_end && (v_q == V_LAST);

    // Raster advance: h steps every tick, v steps when h wraps
    always_comb begin
        phase_d = ~phase_q;
        h_d     = h_q;
        v_d     = v_q;
        if (pix_en) begin
            if (line_end) begin
                h_d = '0;
                v_d = frame_end ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
        frame_start_d = pix_en && (h_q == 10'd0) && (v_q == 10'd0);
    end

    // Counter state; synchronous reset restarts the raster at h=0, v=0
    always_ff @(posedge clk) begin
        if (!resetn) begin
            phase_q       <= 1'b0;
            h_q           <= '0;
            v_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            h_q           <= h_d;
            v_q           <= v_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_en_o      = pix_en;
    assign phase_o       = phase_q;
    assign col_o         = h_q[9:2];
    assign v_o           = v_q;
    assign line_end_o    = line_end;
    assign frame_end_o   = frame_end;
    assign hs_n_o        = !((h_q >= H_SYNC_LO) && (h_q < H_SYNC_HI));
    assign vs_n_o        = !((v_q >= V_SYNC_LO) && (v_q < V_SYNC_HI));
    assign vis_o         = (h_q < H_VIS_END) && (v_q < V_VIS_END);
    assign vblank_o      = (v_q >= V_VIS_END);
    assign frame_start_o = frame_start_q;

endmodule

// File: rtl/vga_scanout.sv
// Reads the 160x120 framebuffer once per 4x4 block and drives 640x480@60 VGA pins.
// Latency: raster position to pins 2 pixel ticks (address+decode stage, then data/colour stage).
// Backpressure: none; framebuffer read port must answer 1 clk after rd_addr.
module vga_scanout #(
    parameter int FB_W     = 160,
    parameter int FB_H     = 120,
    parameter int ADDR_W   = 15,
    parameter int COLOUR_W = 3,
    parameter int DAC_W    = 10
) (
    input  logic                clk,
    input  logic                resetn,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [COLOUR_W-1:0] rd_data,
    output logic [DAC_W-1:0]    VGA_R,
    output logic [DAC_W-1:0]    VGA_G,
    output logic [DAC_W-1:0]    VGA_B,
    output logic                VGA_HS,
    output logic                VGA_VS,
    output logic                VGA_BLANK_N,
    output logic                VGA_SYNC_N,
    output logic                VGA_CLK,
    output logic                frame_start,
    output logic                vblank
);

    import vga_pkg::colour_t;

    // The last screen line of the playfield; no row step after it
    localparam logic [9:0]        V_LAST_ROW = 10'(4 * FB_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(FB_W);

    logic       pix_en;
    logic       phase;
    logic [7:0] col;
    logic [9:0] v;
    logic       line_end;
    logic       frame_end;
    logic       hs_n;
    logic       vs_n;
    logic       vis;

    vga_timing u_timing (
        .clk           (clk),
        .resetn        (resetn),
        .pix_en_o      (pix_en),
        .phase_o       (phase),
        .col_o         (col),
        .v_o           (v),
        .line_end_o    (line_end),
        .frame_end_o   (frame_end),
        .hs_n_o        (hs_n),
        .vs_n_o        (vs_n),
        .vis_o         (vis),
        .vblank_o      (vblank),
        .frame_start_o (frame_start)
    );

    // Row base accumulates FB_W every 4 lines so no multiplier is needed
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

    // Stage 0: decode registered alongside the read address
    logic hs0_q, vs0_q, vis0_q;
    // Stage 1: pins, aligned with the returned framebuffer word
    logic             hs1_q, vs1_q, vis1_q;
    logic [DAC_W-1:0] r_q, g_q, b_q;
    logic [DAC_W-1:0] r_d, g_d, b_d;

    colour_t px;
    assign px = colour_t'(rd_data);

    // Address generation: frame wrap clears the row base ahead of any row step
    always_comb begin
        row_base_d = row_base_q;
        if (frame_end) begin
            row_base_d = '0;
        end else if (line_end && (v[1:0] == 2'd3) && (v < V_LAST_ROW)) begin
            row_base_d = row_base_q + ROW_STEP;
        end

        rd_addr_d = rd_addr_q;
        if (pix_en && vis) begin
            rd_addr_d = row_base_q + ADDR_W'(col);
        end
    end

    // Colour expansion; the blank flag from stage 0 belongs to the word now on rd_data
    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (vis0_q) begin
            r_d = {DAC_W{px[2]}};
            g_d = {DAC_W{px[1]}};
            b_d = {DAC_W{px[0]}};
        end
    end

    // Address and two-stage pixel pipeline, advancing on pixel ticks only
    always_ff @(posedge clk) begin
        if (!resetn) begin
            row_base_q <= '0;
            rd_addr_q  <= '0;
            hs0_q      <= 1'b1;
            vs0_q      <= 1'b1;
            vis0_q     <= 1'b0;
            hs1_q      <= 1'b1;
            vs1_q      <= 1'b1;
            vis1_q     <= 1'b0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
        end else begin
            row_base_q <= row_base_d;
            rd_addr_q  <= rd_addr_d;
            if (pix_en) begin
                hs0_q  <= hs_n;
                vs0_q  <= vs_n;
                vis0_q <= vis;
                hs1_q  <= hs0_q;
                vs1_q  <= vs0_q;
                vis1_q <= vis0_q;
                r_q    <= r_d;
                g_q    <= g_d;
                b_q    <= b_d;
            end
        end
    end

    assign rd_addr     = rd_addr_q;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign VGA_HS      = hs1_q;
    assign VGA_VS      = vs1_q;
    assign VGA_BLANK_N = vis1_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = phase;

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout: hand-derived vectors, corner sequences, random runs vs a raster model.
// Latency: n/a.
// Backpressure: n/a.
module tb_vga_scanout;

    localparam int ADDR_W = 15;
    localparam int DAC_W  = 10;

    logic              clk    = 1'b0;
    logic              resetn = 1'b0;
    logic [ADDR_W-1:0] rd_addr;
    logic [2:0]        rd_data = 3'd0;
    logic [DAC_W-1:0]  VGA_R, VGA_G, VGA_B;
    logic              VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;
    logic              frame_start, vblank;

    int n_vec = 0;
    int n_bad = 0;
    int k     = 0;   // clk edges since resetn was last released; 0 while held in reset

    logic [2:0] ram_mask = 3'b111;
    logic [2:0] ram_xor  = 3'b000;

    vga_scanout dut (
        .clk         (clk),
        .resetn      (resetn),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_BLANK_N (VGA_BLANK_N),
        .VGA_SYNC_N  (VGA_SYNC_N),
        .VGA_CLK     (VGA_CLK),
        .frame_start (frame_start),
        .vblank      (vblank)
    );

    always #10 clk = ~clk;

    // Synchronous framebuffer: word for the address presented one clk earlier
    always @(posedge clk) rd_data <= (rd_addr[2:0] & ram_mask) ^ ram_xor;

    logic [51:0] got;
    assign got = {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_CLK, frame_start, vblank, VGA_SYNC_N,
                  VGA_R, VGA_G, VGA_B, rd_addr};

    // ---------------- reference model ----------------
    typedef struct {
        logic hs, vs, bn, vclk, fs, vb;
        logic [9:0] r, g, b;
        int addr;
    } pins_t;

    function automatic int addr_of(int h, int v);
        return (v / 4) * 160 + h / 4;
    endfunction

    function automatic logic [2:0] ram_of(int a);
        logic [14:0] av;
        av = a[14:0];
        return (av[2:0] & ram_mask) ^ ram_xor;
    endfunction

    // Pixel tick n lands on clk edge 2n. Tick n registers raster pixel n-1 (read address and decode);
    // tick n+1 puts that pixel on the pins together with its framebuffer word.
    function automatic pins_t model(int kk);
        pins_t e;
        int n, p, q, h, v;
        logic [2:0] c;
        n      = kk / 2;
        e.vclk = (kk % 2) == 1;
        e.fs   = ((kk % 2) == 0) && (n >= 1) && (((n - 1) % 420000) == 0);
        e.vb   = ((n / 800) % 525) >= 480;
        if (n == 0) begin
            e.addr = 0;
        end else begin
            q = n - 1;
            h = q % 800;
            v = (q / 800) % 525;
            e.addr = (v < 480) ? addr_of((h < 640) ? h : 639, v) : 19199;
        end
        e.hs = 1'b1; e.vs = 1'b1; e.bn = 1'b0;
        e.r = '0; e.g = '0; e.b = '0;
        if (n >= 2) begin
            p = n - 2;
            h = p % 800;
            v = (p / 800) % 525;
            e.hs = !(h >= 656 && h < 752);
            e.vs = !(v >= 490 && v < 492);
            e.bn = (h < 640) && (v < 480);
            if (e.bn) begin
                c   = ram_of(addr_of(h, v));
                e.r = {10{c[2]}};
                e.g = {10{c[1]}};
                e.b = {10{c[0]}};
            end
        end
        return e;
    endfunction

    function automatic logic [51:0] pack_exp(pins_t e);
        return {e.hs, e.vs, e.bn, e.vclk, e.fs, e.vb, 1'b0, e.r, e.g, e.b, 15'(e.addr)};
    endfunction

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        if (resetn) k++;
        else        k = 0;
    endtask

    task automatic do_reset(int cycles);
        resetn = 1'b0;
        for (int i = 0; i < cycles; i++) step();
        resetn = 1'b1;
    endtask

    task automatic check_int(string tag, int actual, int required);
        n_vec++;
        if (actual !== required) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, required);
        end
    endtask

    task automatic check_now(string tag);
        logic [51:0] ex;
        ex = pack_exp(model(k));
        n_vec++;
        if (got !== ex) begin
            n_bad++;
            $display("FAIL %s k=%0d: got %h, expected %h", tag, k, got, ex);
        end
    endtask

    // Every clk is compared; each 100-clk window counts as one vector
    task automatic run_checked(int nsteps, string tag);
        logic [51:0] ex, first_got, first_exp;
        int bad_steps, first_k;
        for (int w = 0; w < nsteps; w += 100) begin
            bad_steps = 0;
            first_got = '0; first_exp = '0; first_k = 0;
            for (int s = 0; s < 100 && (w + s) < nsteps; s++) begin
                step();
                ex = pack_exp(model(k));
                if (got !== ex) begin
                    if (bad_steps == 0) begin
                        first_got = got; first_exp = ex; first_k = k;
                    end
                    bad_steps++;
                end
            end
            n_vec++;
            if (bad_steps != 0) begin
                n_bad++;
                $display("FAIL %s k=%0d: got %h, expected %h (%0d bad clk in window)",
                         tag, first_k, first_got, first_exp, bad_steps);
            end
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int         k;
        logic       hs, bn, vclk, fs;
        logic [2:0] rgb;
        int         addr;
    } vec_t;

    localparam int NTAB = 15;
    vec_t tab [NTAB];

    initial begin
        int fall_k, fall2_k, low, vis_cnt, viol, err, tgt;
        logic prev;
        logic [48:0] g49, e49;

        // framebuffer returns addr[2:0]
        //            k      hs bn clk fs  rgb     addr
        tab[0]  = '{0,     1, 0, 0, 0, 3'b000, 0};
        tab[1]  = '{1,     1, 0, 1, 0, 3'b000, 0};
        tab[2]  = '{2,     1, 0, 0, 1, 3'b000, 0};
        tab[3]  = '{3,     1, 0, 1, 0, 3'b000, 0};
        tab[4]  = '{4,     1, 1, 0, 0, 3'b000, 0};
        tab[5]  = '{12,    1, 1, 0, 0, 3'b001, 1};
        tab[6]  = '{20,    1, 1, 0, 0, 3'b010, 2};
        tab[7]  = '{1282,  1, 1, 0, 0, 3'b111, 159};
        tab[8]  = '{1284,  1, 0, 0, 0, 3'b000, 159};
        tab[9]  = '{1316,  0, 0, 0, 0, 3'b000, 159};
        tab[10] = '{1506,  0, 0, 0, 0, 3'b000, 159};
        tab[11] = '{1508,  1, 0, 0, 0, 3'b000, 159};
        tab[12] = '{6444,  1, 1, 0, 0, 3'b101, 165};
        tab[13] = '{12482, 1, 1, 0, 0, 3'b111, 319};
        tab[14] = '{12804, 1, 1, 0, 0, 3'b000, 320};

        ram_mask = 3'b111;
        ram_xor  = 3'b000;
        resetn   = 1'b0;
        for (int i = 0; i < 5; i++) step();

        for (int i = 0; i < NTAB; i++) begin
            if (tab[i].k > 0) resetn = 1'b1;
            while (k < tab[i].k) step();
            g49 = {VGA_HS, VGA_BLANK_N, VGA_CLK, frame_start, VGA_R, VGA_G, VGA_B, rd_addr};
            e49 = {tab[i].hs, tab[i].bn, tab[i].vclk, tab[i].fs,
                   {10{tab[i].rgb[2]}}, {10{tab[i].rgb[1]}}, {10{tab[i].rgb[0]}}, 15'(tab[i].addr)};
            n_vec++;
            if (g49 !== e49) begin
                n_bad++;
                $display("FAIL vec%0d k=%0d: got %h, expected %h", i, tab[i].k, g49, e49);
            end
        end

        // HS edge, width and line period
        do_reset(3);
        fall_k = -1;
        for (int s = 0; s < 4000 && fall_k < 0; s++) begin
            prev = VGA_HS;
            step();
            if (prev && !VGA_HS) fall_k = k;
        end
        check_int("hs_first_fall_clk", fall_k, 1316);
        low = 0;
        while (!VGA_HS && low < 400) begin
            step();
            low++;
        end
        check_int("hs_low_clk", low, 192);
        fall2_k = -1;
        for (int s = 0; s < 2000 && fall2_k < 0; s++) begin
            prev = VGA_HS;
            step();
            if (prev && !VGA_HS) fall2_k = k;
        end
        check_int("line_period_clk", fall2_k - fall_k, 1600);

        // Colour/blank alignment with a uniform 3'b101 framebuffer
        resetn   = 1'b0;
        ram_mask = 3'b000;
        ram_xor  = 3'b101;
        do_reset(2);
        vis_cnt = 0;
        viol    = 0;
        for (int s = 0; s < 2900; s++) begin
            step();
            if (VGA_BLANK_N) begin
                vis_cnt++;
                if ({VGA_R, VGA_G, VGA_B} !== {10'h3FF, 10'h000, 10'h3FF}) viol++;
            end else if ({VGA_R, VGA_G, VGA_B} !== 30'd0) begin
                viol++;
            end
        end
        check_int("colour_blank_violations", viol, 0);
        check_int("visible_clk_two_lines", vis_cnt, 2560);

        // Address sweep on screen line 7
        resetn   = 1'b0;
        ram_mask = 3'b111;
        ram_xor  = 3'b000;
        do_reset(2);
        while (k < 11202) step();
        err = 0;
        for (int i = 0; i < 640; i++) begin
            if (rd_addr !== 15'(160 + i / 4)) err++;
            step();
            step();
        end
        check_int("line7_addr_errors", err, 0);
        check_int("line7_addr_hold", int'(rd_addr), 319);

        // Randomised runs against the raster model, with a reset pulse mid-frame
        resetn   = 1'b0;
        ram_mask = 3'b111;
        ram_xor  = 3'($urandom_range(0, 7));
        do_reset(int'($urandom_range(1, 4)));
        tgt = 2 * (10 * 800 + 400 + int'($urandom_range(0, 300)));
        run_checked(tgt, "rand_run1");
        resetn = 1'b0;
        step();
        check_now("mid_frame_reset");
        check_int("mid_frame_reset_addr", int'(rd_addr), 0);
        resetn  = 1'b1;
        ram_xor = 3'($urandom_range(0, 7));
        run_checked(6000, "rand_run2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
